alarm_responder: RTL and testbench
==================================

// Module: alarm_responder
// PURPOSE
//  Consumer of the alarm-clock match signal: converts the raw "time == alarm" level into a
//  user-facing alarm. It blinks the LEDs and gates the buzzer, handles stop (push2) and
//  snooze (push3), and auto-silences after a timeout. Sits between the alarm_clock
//  comparison output and the board LEDG/buzzer pins, in the clk50 domain.
// PARAMETERS
//  SNOOZE_SEC  300  seconds spent in SNOOZE before re-ringing
//  RING_SEC    60   seconds of unanswered ringing before auto-off (sets missed)
//  MAX_SNOOZE  3    snoozes allowed per alarm event; further snooze presses are ignored
//  CNT_W       9    width of sec counters; must hold max(SNOOZE_SEC, RING_SEC)
// PORTS
//  clk50        in   1      system clock, 50 MHz, all logic on rising edge
//  reset_n      in   1      asynchronous, active-low reset
//  tick_1hz     in   1      one-clk50-cycle strobe per second (from clock generator)
//  alarm_match  in   1      level, high while current hh:mm equals any alarm slot
//  push2        in   1      raw pushbutton, active-low, asynchronous: STOP
//  push3        in   1      raw pushbutton, active-low, asynchronous: SNOOZE
//  ledg         out  8      alarm LEDs
//  buzzer       out  1      buzzer enable
//  state_o      out  2      current state: 0 IDLE, 1 RINGING, 2 SNOOZE, 3 DONE
//  snooze_cnt   out  2      snoozes used in current event
//  missed       out  1      sticky: an alarm timed out unanswered
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE, ledg=0, buzzer=0, snooze_cnt=0, missed=0,
//   counters 0, blink phase 0. Button sync FFs reset to 1 (released), match_d to 0.
//  Inputs: push2/push3 each pass a 2-FF synchronizer plus a prev-FF. A press is the 1->0
//   edge of the synced value, a one-cycle pulse. State reacts on the 3rd rising edge at
//   which the raw button is sampled low. Holding a button gives one press only.
//  match_rise = alarm_match & ~match_d. match_d is registered every cycle.
//  FSM (all outputs registered, they update on the same edge as state):
//   IDLE:    match_rise -> RINGING; ring_cnt<=RING_SEC, phase<=1.
//   RINGING: stop -> DONE.
//            snooze & snooze_cnt<MAX_SNOOZE -> SNOOZE; snz_cnt<=SNOOZE_SEC, snooze_cnt++.
//            snooze at MAX_SNOOZE: ignored, keep ringing.
//            tick: phase toggles; ring_cnt--. tick with ring_cnt==1 -> DONE, missed<=1.
//   SNOOZE:  stop -> DONE. tick: snz_cnt--. tick with snz_cnt==1 -> RINGING;
//            ring_cnt<=RING_SEC, phase<=1. Snooze presses are ignored.
//   DONE:    alarm_match==0 -> IDLE, snooze_cnt<=0. Otherwise stay; re-trigger within
//            the same matching minute is impossible.
//  Outputs: ledg=8'hFF and buzzer=1 when RINGING & phase. ledg=8'h01 in SNOOZE.
//   Otherwise ledg=0, buzzer=0.
//  Priority in the same cycle: stop > snooze > tick. A button beats a simultaneous tick,
//   and counters load rather than decrement.
//  match_rise outside IDLE is ignored. A match that stays high across a snooze does not
//   re-trigger.
//  missed clears on a stop press in any state.
//  Reset mid-ring forces IDLE and silences outputs asynchronously. If alarm_match is
//   still high after release, match_d=0 yields a fresh match_rise and rings again.
// TESTING (sim params SNOOZE_SEC=3, RING_SEC=5, MAX_SNOOZE=2)
//  1 alarm_match 0->1 -> state_o=1, ledg=FF, buzzer=1 next edge; ledg toggles FF/00 each tick
//  2 RINGING, push3 low 4 cycles -> SNOOZE on 3rd edge, ledg=01, snooze_cnt=1; 3 ticks -> RINGING
//  3 snooze twice then push3 again -> stays RINGING, snooze_cnt=2
//  4 no response, 5 ticks -> DONE, missed=1, ledg=0; match drops -> IDLE, snooze_cnt=0
//  5 push2 and push3 pressed together while RINGING -> DONE (stop wins), snooze_cnt unchanged
//  6 reset_n low mid-ring with match high -> ledg=0 at once; release -> RINGING again

Source files
------------

// File: rtl/alarm_responder.sv
// alarm_responder: turns the raw "time == alarm" level into a user-facing alarm.
// Blinks the LEDs and gates the buzzer while ringing. Handles STOP (push2) and
// SNOOZE (push3). Auto-silences after RING_SEC unanswered seconds, and flags
// that timeout through the sticky missed output.
module alarm_responder #(
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned MAX_SNOOZE = 3,
  parameter int unsigned CNT_W      = 9
) (
  input  logic       clk50,
  input  logic       reset_n,
  input  logic       tick_1hz,
  input  logic       alarm_match,
  input  logic       push2,
  input  logic       push3,
  output logic [7:0] ledg,
  output logic       buzzer,
  output logic [1:0] state_o,
  output logic [1:0] snooze_cnt,
  output logic       missed
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRinging = 2'd1,
    StSnooze  = 2'd2,
    StDone    = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] RingLoad   = CNT_W'(RING_SEC);
  localparam logic [CNT_W-1:0] SnoozeLoad = CNT_W'(SNOOZE_SEC);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  // Button synchronizers. They reset to 1, the released level of an active-low button.
  logic [1:0] stop_sync_q;
  logic       stop_prev_q;
  logic [1:0] snz_sync_q;
  logic       snz_prev_q;
  logic       stop_press;
  logic       snz_press;

  // 2-FF synchronizer plus previous-value FF for edge detection on each button.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      stop_sync_q <= 2'b11;
      stop_prev_q <= 1'b1;
      snz_sync_q  <= 2'b11;
      snz_prev_q  <= 1'b1;
    end else begin
      stop_sync_q <= {stop_sync_q[0], push2};
      stop_prev_q <= stop_sync_q[1];
      snz_sync_q  <= {snz_sync_q[0], push3};
      snz_prev_q  <= snz_sync_q[1];
    end
  end

  // A press is the 1->0 edge of the synced level, so a held button counts once.
  assign stop_press = stop_prev_q & ~stop_sync_q[1];
  assign snz_press  = snz_prev_q & ~snz_sync_q[1];

  // Match edge detection.
  logic match_q;
  logic match_rise;

  // Delayed copy of alarm_match, updated every cycle.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      match_q <= 1'b0;
    end else begin
      match_q <= alarm_match;
    end
  end

  assign match_rise = alarm_match & ~match_q;

  // Main FSM state and datapath registers.
  state_e           state_q, state_d;
  logic [CNT_W-1:0] ring_cnt_q, ring_cnt_d;
  logic [CNT_W-1:0] snz_cnt_q, snz_cnt_d;
  logic             phase_q, phase_d;
  logic [1:0]       snooze_cnt_q, snooze_cnt_d;
  logic             missed_q, missed_d;
  logic [7:0]       ledg_q, ledg_d;
  logic             buzzer_q, buzzer_d;
  logic             snooze_allowed;

  assign snooze_allowed = 32'(snooze_cnt_q) < MAX_SNOOZE;

  // State and output registers. Outputs update on the same edge as the state.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      ring_cnt_q   <= '0;
      snz_cnt_q    <= '0;
      phase_q      <= 1'b0;
      snooze_cnt_q <= 2'd0;
      missed_q     <= 1'b0;
      ledg_q       <= 8'h00;
      buzzer_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ring_cnt_q   <= ring_cnt_d;
      snz_cnt_q    <= snz_cnt_d;
      phase_q      <= phase_d;
      snooze_cnt_q <= snooze_cnt_d;
      missed_q     <= missed_d;
      ledg_q       <= ledg_d;
      buzzer_q     <= buzzer_d;
    end
  end

  // Next-state logic. Priority is stop > snooze > tick: a button press loads
  // the counters and swallows a simultaneous tick.
  always_comb begin
    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    snz_cnt_d    = snz_cnt_q;
    phase_d      = phase_q;
    snooze_cnt_d = snooze_cnt_q;
    missed_d     = missed_q;

    // Stop acknowledges a missed alarm in any state.
    if (stop_press) begin
      missed_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (match_rise) begin
          state_d    = StRinging;
          ring_cnt_d = RingLoad;
          phase_d    = 1'b1;
        end
      end
      StRinging: begin
        if (stop_press) begin
          state_d = StDone;
        end else if (snz_press && snooze_allowed) begin
          state_d      = StSnooze;
          snz_cnt_d    = SnoozeLoad;
          snooze_cnt_d = snooze_cnt_q + 2'd1;
        end else if (tick_1hz) begin
          if (ring_cnt_q == CntOne) begin
            state_d  = StDone;
            missed_d = 1'b1;
          end else begin
            ring_cnt_d = ring_cnt_q - CntOne;
            phase_d    = ~phase_q;
          end
        end
      end
      StSnooze: begin
        // Further snooze presses are ignored here.
        if (stop_press) begin
          state_d = StDone;
        end else if (tick_1hz) begin
          if (snz_cnt_q == CntOne) begin
            state_d    = StRinging;
            ring_cnt_d = RingLoad;
            phase_d    = 1'b1;
          end else begin
            snz_cnt_d = snz_cnt_q - CntOne;
          end
        end
      end
      StDone: begin
        // Wait for the matching minute to end so the same match cannot re-arm.
        if (!alarm_match) begin
          state_d      = StIdle;
          snooze_cnt_d = 2'd0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode from the next state, so the outputs are registered with the state.
  always_comb begin
    ledg_d   = 8'h00;
    buzzer_d = 1'b0;
    if (state_d == StRinging && phase_d) begin
      ledg_d   = 8'hFF;
      buzzer_d = 1'b1;
    end else if (state_d == StSnooze) begin
      ledg_d = 8'h01;
    end
  end

  assign ledg       = ledg_q;
  assign buzzer     = buzzer_q;
  assign state_o    = state_q;
  assign snooze_cnt = snooze_cnt_q;
  assign missed     = missed_q;

endmodule

// File: tb/tb_alarm_responder.sv
// Directed bench for alarm_responder with short sim timeouts.
module tb_alarm_responder;

  logic       clk50;
  logic       reset_n;
  logic       tick_1hz;
  logic       alarm_match;
  logic       push2;
  logic       push3;
  logic [7:0] ledg;
  logic       buzzer;
  logic [1:0] state_o;
  logic [1:0] snooze_cnt;
  logic       missed;

  int n_cmp;
  int n_bad;

  alarm_responder #(
    .SNOOZE_SEC(3),
    .RING_SEC  (5),
    .MAX_SNOOZE(2),
    .CNT_W     (9)
  ) dut (
    .clk50      (clk50),
    .reset_n    (reset_n),
    .tick_1hz   (tick_1hz),
    .alarm_match(alarm_match),
    .push2      (push2),
    .push3      (push3),
    .ledg       (ledg),
    .buzzer     (buzzer),
    .state_o    (state_o),
    .snooze_cnt (snooze_cnt),
    .missed     (missed)
  );

  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are checked on the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk50);
  endtask

  task automatic do_tick();
    tick_1hz = 1'b1;
    cyc(1);
    tick_1hz = 1'b0;
  endtask

  // Drive buttons low for two edges; the third edge is the one the FSM reacts on.
  task automatic press_start(input logic p2, input logic p3);
    push2 = ~p2;
    push3 = ~p3;
    cyc(2);
  endtask

  task automatic release_all();
    cyc(1);
    push2 = 1'b1;
    push3 = 1'b1;
    cyc(3);
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    reset_n     = 1'b0;
    tick_1hz    = 1'b0;
    alarm_match = 1'b0;
    push2       = 1'b1;
    push3       = 1'b1;
    cyc(2);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_ledg", 32'(ledg), 32'h00);
    chk("rst_buzzer", 32'(buzzer), 32'd0);
    chk("rst_snzcnt", 32'(snooze_cnt), 32'd0);
    chk("rst_missed", 32'(missed), 32'd0);
    reset_n = 1'b1;
    cyc(3);
    chk("idle_state", 32'(state_o), 32'd0);

    // 1: match rise rings, LEDs blink per tick.
    alarm_match = 1'b1;
    cyc(1);
    chk("t1_state", 32'(state_o), 32'd1);
    chk("t1_ledg", 32'(ledg), 32'hFF);
    chk("t1_buzzer", 32'(buzzer), 32'd1);
    do_tick();
    chk("t1_tick1_ledg", 32'(ledg), 32'h00);
    chk("t1_tick1_buz", 32'(buzzer), 32'd0);
    do_tick();
    chk("t1_tick2_ledg", 32'(ledg), 32'hFF);

    // 2: snooze on third edge, three ticks back to ringing.
    press_start(1'b0, 1'b1);
    chk("t2_pre_state", 32'(state_o), 32'd1);
    cyc(1);
    chk("t2_state", 32'(state_o), 32'd2);
    chk("t2_ledg", 32'(ledg), 32'h01);
    chk("t2_buzzer", 32'(buzzer), 32'd0);
    chk("t2_snzcnt", 32'(snooze_cnt), 32'd1);
    release_all();
    press_start(1'b0, 1'b1);
    cyc(1);
    release_all();
    chk("t2_snz_ignored", 32'(snooze_cnt), 32'd1);
    do_tick();
    do_tick();
    chk("t2_tick2_state", 32'(state_o), 32'd2);
    do_tick();
    chk("t2_tick3_state", 32'(state_o), 32'd1);
    chk("t2_tick3_ledg", 32'(ledg), 32'hFF);

    // 3: second snooze, then a third press is ignored.
    press_start(1'b0, 1'b1);
    cyc(1);
    release_all();
    chk("t3_state_snz", 32'(state_o), 32'd2);
    chk("t3_snzcnt", 32'(snooze_cnt), 32'd2);
    do_tick();
    do_tick();
    do_tick();
    chk("t3_back_ring", 32'(state_o), 32'd1);
    press_start(1'b0, 1'b1);
    cyc(1);
    release_all();
    chk("t3_max_state", 32'(state_o), 32'd1);
    chk("t3_max_snzcnt", 32'(snooze_cnt), 32'd2);

    // 4: unanswered ringing times out after 5 ticks.
    for (int i = 0; i < 4; i++) do_tick();
    chk("t4_tick4_state", 32'(state_o), 32'd1);
    chk("t4_tick4_ledg", 32'(ledg), 32'hFF);
    do_tick();
    chk("t4_state", 32'(state_o), 32'd3);
    chk("t4_missed", 32'(missed), 32'd1);
    chk("t4_ledg", 32'(ledg), 32'h00);
    chk("t4_buzzer", 32'(buzzer), 32'd0);
    alarm_match = 1'b0;
    cyc(1);
    chk("t4_idle", 32'(state_o), 32'd0);
    chk("t4_snzcnt", 32'(snooze_cnt), 32'd0);
    chk("t4_missed_sticky", 32'(missed), 32'd1);

    // 5: stop and snooze together, stop wins and clears missed.
    alarm_match = 1'b1;
    cyc(1);
    chk("t5_ring", 32'(state_o), 32'd1);
    press_start(1'b0, 1'b1);
    cyc(1);
    release_all();
    do_tick();
    do_tick();
    do_tick();
    chk("t5_reringing", 32'(state_o), 32'd1);
    press_start(1'b1, 1'b1);
    cyc(1);
    chk("t5_state", 32'(state_o), 32'd3);
    chk("t5_snzcnt", 32'(snooze_cnt), 32'd1);
    chk("t5_missed_clr", 32'(missed), 32'd0);
    release_all();
    cyc(3);
    chk("t5_no_retrig", 32'(state_o), 32'd3);
    alarm_match = 1'b0;
    cyc(1);
    chk("t5_idle", 32'(state_o), 32'd0);

    // 6: async reset mid-ring, then re-ring with match still high.
    alarm_match = 1'b1;
    cyc(2);
    chk("t6_ring", 32'(ledg), 32'hFF);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_async_ledg", 32'(ledg), 32'h00);
    chk("t6_async_buz", 32'(buzzer), 32'd0);
    chk("t6_async_state", 32'(state_o), 32'd0);
    cyc(1);
    reset_n = 1'b1;
    cyc(1);
    chk("t6_rering", 32'(state_o), 32'd1);
    chk("t6_rering_ledg", 32'(ledg), 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
